// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register:
// mode encodings and the burst sequencer state type.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_t;

endpackage

// File: rtl/universal_shift_core.sv
// Shift register datapath: holds q and selects the next value
// from the resolved operation, rotate flag and serial inputs.
module universal_shift_core
  import usr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [1:0]   i_op,
  input  logic         i_rot,
  input  logic         i_dsr,
  input  logic         i_dsl,
  input  logic [N-1:0] i_pd,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;
  logic [N-1:0] w_next;
  logic         w_fill_r;
  logic         w_fill_l;

  assign w_fill_r = i_rot ? r_q[0]   : i_dsr;
  assign w_fill_l = i_rot ? r_q[N-1] : i_dsl;

  always_comb begin
    w_next = r_q;
    unique case (i_op)
      MODE_HOLD: w_next = r_q;
      MODE_SHR:  w_next = {w_fill_r, r_q[N-1:1]};
      MODE_SHL:  w_next = {r_q[N-2:0], w_fill_l};
      MODE_LOAD: w_next = i_pd;
      default:   w_next = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with a counted burst sequencer;
// the datapath lives in universal_shift_core.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          rot,
  input  logic          dsr,
  input  logic          dsl,
  input  logic [N-1:0]  pd,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  q,
  output logic          sor,
  output logic          sol,
  output logic          busy,
  output logic          done
);

  usr_state_t    r_state;
  usr_state_t    w_state_nxt;
  logic [CW-1:0] r_rem;
  logic          r_dir_left;
  logic          r_rot;
  logic          r_done;

  logic          w_is_shift;
  logic          w_accept;
  logic          w_cnt_zero;
  logic          w_cnt_multi;
  logic          w_last;
  logic [1:0]    w_op;
  logic          w_rot;

  assign w_is_shift  = (mode == MODE_SHR) || (mode == MODE_SHL);
  assign w_accept    = en && (r_state == IDLE) && start && w_is_shift;
  assign w_cnt_zero  = (cnt == '0);
  assign w_cnt_multi = (cnt > CW'(1));
  assign w_last      = en && (r_state == RUN) && (r_rem == CW'(1));

  // A burst overrides the live mode; a zero-length burst only pulses done.
  always_comb begin
    w_op  = mode;
    w_rot = rot;
    if (r_state == RUN) begin
      w_op  = r_dir_left ? MODE_SHL : MODE_SHR;
      w_rot = r_rot;
    end else if (w_accept && w_cnt_zero) begin
      w_op  = MODE_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_accept && w_cnt_multi) w_state_nxt = RUN;
      RUN:  if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem      <= '0;
      r_dir_left <= 1'b0;
      r_rot      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (w_accept && !w_cnt_multi) || w_last;
      if (w_accept) begin
        r_rem      <= w_cnt_zero ? '0 : cnt - CW'(1);
        r_dir_left <= (mode == MODE_SHL);
        r_rot      <= rot;
      end else if (en && r_state == RUN) begin
        r_rem <= r_rem - CW'(1);
      end
    end
  end

  universal_shift_core #(
    .N (N)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .i_en  (en),
    .i_op  (w_op),
    .i_rot (w_rot),
    .i_dsr (dsr),
    .i_dsl (dsl),
    .i_pd  (pd),
    .o_q   (q)
  );

  assign sor  = q[0];
  assign sol  = q[N-1];
  assign done = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench: behavioural model plus directed and
// randomized stimulus for universal_shift_register.
module tb_universal_shift_register;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          rot = 1'b0;
  logic          dsr = 1'b0;
  logic          dsl = 1'b0;
  logic [N-1:0]  pd = '0;
  logic          start = 1'b0;
  logic [CW-1:0] cnt = '0;
  logic [N-1:0]  q;
  logic          sor;
  logic          sol;
  logic          busy;
  logic          done;

  int vecs = 0;
  int errs = 0;

  logic [7:0] m_q;
  bit         m_busy;
  bit         m_done;
  int         m_rem;
  bit         m_left;
  bit         m_rot;

  universal_shift_register #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .rot   (rot),
    .dsr   (dsr),
    .dsl   (dsl),
    .pd    (pd),
    .start (start),
    .cnt   (cnt),
    .q     (q),
    .sor   (sor),
    .sol   (sol),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f_shift(logic [7:0] v, bit left,
                                         bit r, bit ir, bit il);
    int u;
    int b;
    u = int'(v);
    if (!left) begin
      b = r ? (u % 2) : int'(ir);
      return 8'((u / 2) + b * 128);
    end
    b = r ? (u / 128) : int'(il);
    return 8'(((u * 2) % 256) + b);
  endfunction

  task automatic model_reset();
    m_q    = 8'h00;
    m_busy = 0;
    m_done = 0;
    m_rem  = 0;
  endtask

  task automatic model_edge();
    int c;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!en) begin
      m_done = 0;
      return;
    end
    c = int'(cnt);
    m_done = 0;
    if (m_busy) begin
      m_q   = f_shift(m_q, m_left, m_rot, dsr, dsl);
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (start && (mode == 2'd1 || mode == 2'd2)) begin
      if (c == 0) begin
        m_done = 1;
      end else begin
        m_q = f_shift(m_q, mode == 2'd2, rot, dsr, dsl);
        if (c == 1) begin
          m_done = 1;
        end else begin
          m_busy = 1;
          m_rem  = c - 1;
          m_left = (mode == 2'd2);
          m_rot  = rot;
        end
      end
    end else begin
      case (mode)
        2'd1: m_q = f_shift(m_q, 0, rot, dsr, dsl);
        2'd2: m_q = f_shift(m_q, 1, rot, dsr, dsl);
        2'd3: m_q = pd;
        default: m_q = m_q;
      endcase
    end
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("q", q, m_q);
    chk("sor", 8'(sor), 8'(m_q[0]));
    chk("sol", 8'(sol), 8'(m_q[7]));
    chk("busy", 8'(busy), 8'(m_busy));
    chk("done", 8'(done), 8'(m_done));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  task automatic mid_reset();
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    cmp_model();
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_model();
    rst = 1'b1;
    en  = 1'b1;

    // load then asynchronous reset mid-cycle
    mode = 2'd3; pd = 8'hA5;
    cyc(); chk("load_a5", q, 8'hA5);
    mid_reset();
    chk("rst_q", q, 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_done", 8'(done), 8'h00);
    cyc();
    rst = 1'b1;

    // serial fill left, then right
    mode = 2'd2; dsl = 1'b1; rot = 1'b0;
    cyc(); chk("shl1", q, 8'h01);
    cyc(); chk("shl2", q, 8'h03);
    cyc(); chk("shl3", q, 8'h07);
    mode = 2'd1; dsr = 1'b0;
    cyc(); chk("shr1", q, 8'h03);

    // rotate-right burst of 3
    mode = 2'd3; pd = 8'h81;
    cyc();
    mode = 2'd1; rot = 1'b1; start = 1'b1; cnt = 4'd3;
    cyc(); chk("b3_1", q, 8'hC0); chk("b3_busy1", 8'(busy), 8'h01);
    start = 1'b0; mode = 2'd0;
    cyc(); chk("b3_2", q, 8'h60); chk("b3_busy2", 8'(busy), 8'h01);
    cyc(); chk("b3_3", q, 8'h30); chk("b3_done", 8'(done), 8'h01);
    chk("b3_idle", 8'(busy), 8'h00);
    cyc(); chk("b3_done_end", 8'(done), 8'h00);

    // burst of 4 with a two-cycle stall and an ignored start
    mode = 2'd3; pd = 8'h5A;
    cyc();
    mode = 2'd2; rot = 1'b0; dsl = 1'b1; start = 1'b1; cnt = 4'd4;
    cyc(); chk("b4_1", q, 8'hB5);
    start = 1'b0; en = 1'b0;
    cyc(); chk("b4_stall_q", q, 8'hB5);
    chk("b4_stall_busy", 8'(busy), 8'h01);
    cyc(); chk("b4_stall_q2", q, 8'hB5);
    en = 1'b1; start = 1'b1; mode = 2'd1; pd = 8'hFF;
    cyc(); chk("b4_2", q, 8'h6B);
    start = 1'b0;
    cyc(); chk("b4_3", q, 8'hD7);
    cyc(); chk("b4_4", q, 8'hAF); chk("b4_done", 8'(done), 8'h01);
    mode = 2'd0;
    cyc(); chk("b4_after", q, 8'hAF); chk("b4_busy0", 8'(busy), 8'h00);

    // zero-length burst
    mode = 2'd1; start = 1'b1; cnt = 4'd0;
    cyc(); chk("c0_q", q, 8'hAF); chk("c0_done", 8'(done), 8'h01);
    chk("c0_busy", 8'(busy), 8'h00);
    start = 1'b0; mode = 2'd0;
    cyc(); chk("c0_done_end", 8'(done), 8'h00);

    // reset aborts a burst of 5
    mode = 2'd1; rot = 1'b1; start = 1'b1; cnt = 4'd5;
    cyc(); chk("b5_1", q, 8'hD7);
    start = 1'b0;
    cyc(); chk("b5_2", q, 8'hEB);
    mid_reset();
    chk("b5_rst_q", q, 8'h00);
    chk("b5_rst_busy", 8'(busy), 8'h00);
    cyc(); chk("b5_no_done", 8'(done), 8'h00);
    rst = 1'b1; mode = 2'd3; pd = 8'h3C;
    cyc(); chk("load_3c", q, 8'h3C); chk("load_done", 8'(done), 8'h00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = 1'b1;
      en    = ($urandom_range(0, 99) < 85);
      mode  = 2'($urandom_range(0, 3));
      rot   = 1'($urandom_range(0, 1));
      dsr   = 1'($urandom_range(0, 1));
      dsl   = 1'($urandom_range(0, 1));
      pd    = 8'($urandom);
      start = ($urandom_range(0, 99) < 20);
      cnt   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) mid_reset();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
